// File: rtl/decode_if.sv
// Bundle between the decode stage and its neighbours: fetch buffer, writeback, hazard info and ID/EX fields.
// The decode stage sits on the slave side; the master side drives the stage inputs and reads the stage outputs.
interface decode_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] pc_fetched;
  logic [WIDTH-1:0] instruction_fetched;
  logic             wb_we;
  logic [4:0]       wb_addr;
  logic [WIDTH-1:0] wb_data;
  logic             ex_reg_write;
  logic             ex_mem_read;
  logic [4:0]       ex_dest;
  logic             mem_mem_read;
  logic [4:0]       mem_dest;

  logic             stall;
  logic             branch_taken;
  logic [WIDTH-1:0] branch_target;
  logic [WIDTH-1:0] id_pc;
  logic [WIDTH-1:0] id_rs_data;
  logic [WIDTH-1:0] id_rt_data;
  logic [WIDTH-1:0] id_imm;
  logic [4:0]       id_dest;
  logic [5:0]       id_opcode;
  logic [5:0]       id_funct;
  logic [4:0]       id_shamt;
  logic             id_alu_src_imm;
  logic             id_reg_write;
  logic             id_mem_read;
  logic             id_mem_write;
  logic             id_link;
  logic             id_illegal;

  modport slave (
    input  pc_fetched, instruction_fetched,
    input  wb_we, wb_addr, wb_data,
    input  ex_reg_write, ex_mem_read, ex_dest, mem_mem_read, mem_dest,
    output stall, branch_taken, branch_target,
    output id_pc, id_rs_data, id_rt_data, id_imm, id_dest, id_opcode, id_funct, id_shamt,
    output id_alu_src_imm, id_reg_write, id_mem_read, id_mem_write, id_link, id_illegal
  );

  modport master (
    output pc_fetched, instruction_fetched,
    output wb_we, wb_addr, wb_data,
    output ex_reg_write, ex_mem_read, ex_dest, mem_mem_read, mem_dest,
    input  stall, branch_taken, branch_target,
    input  id_pc, id_rs_data, id_rt_data, id_imm, id_dest, id_opcode, id_funct, id_shamt,
    input  id_alu_src_imm, id_reg_write, id_mem_read, id_mem_write, id_link, id_illegal
  );
endinterface

// File: rtl/decode_stage.sv
// MIPS R2000 ID stage: register file, field decode, hazard stall, beq/bne/j/jal resolution, ID/EX buffer.
// One cycle fetch buffer -> id_*; stall and branch outputs are combinational, stall replays from a local holder.
module decode_stage #(
  parameter int WIDTH     = 32,
  parameter int REG_COUNT = 32
) (
  input  logic     clk,
  input  logic     rst,
  decode_if.slave  bus
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0a;
  localparam logic [5:0] OP_SLTIU = 6'h0b;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_XORI  = 6'h0e;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_SRA  = 6'h03;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26;
  localparam logic [5:0] F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2a;
  localparam logic [5:0] F_SLTU = 6'h2b;

  typedef struct packed {
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] rs_data;
    logic [WIDTH-1:0] rt_data;
    logic [WIDTH-1:0] imm;
    logic [4:0]       dest;
    logic [5:0]       opcode;
    logic [5:0]       funct;
    logic [4:0]       shamt;
    logic             alu_src_imm;
    logic             reg_write;
    logic             mem_read;
    logic             mem_write;
    logic             link;
    logic             illegal;
  } idex_t;

  logic [WIDTH-1:0] regs_q [REG_COUNT];

  logic             hold_valid_q, hold_valid_d;
  logic [WIDTH-1:0] hold_instr_q, hold_instr_d;
  logic [WIDTH-1:0] hold_pc_q,    hold_pc_d;

  idex_t            idex_q, idex_d;

  logic [WIDTH-1:0] cur_instr, cur_pc;
  logic [5:0]       opcode, funct;
  logic [4:0]       rs, rt, rd, shamt;
  logic [15:0]      imm16;
  logic [WIDTH-1:0] imm_ext;
  logic [WIDTH-1:0] rs_data, rt_data;

  logic             legal, uses_rs, uses_rt;
  logic             alu_src_imm, mem_read, mem_write, link;
  logic             is_beq, is_bne, is_jump;
  logic [4:0]       dest;

  logic             ex_hit_rs, ex_hit_rt, mem_hit_rs, mem_hit_rt;
  logic             load_use, branch_hazard, stall;
  logic             taken_raw, taken;
  logic [WIDTH-1:0] pc_plus4, br_offset, target;

  assign cur_instr = hold_valid_q ? hold_instr_q : bus.instruction_fetched;
  assign cur_pc    = hold_valid_q ? hold_pc_q    : bus.pc_fetched;

  assign opcode = cur_instr[31:26];
  assign rs     = cur_instr[25:21];
  assign rt     = cur_instr[20:16];
  assign rd     = cur_instr[15:11];
  assign shamt  = cur_instr[10:6];
  assign funct  = cur_instr[5:0];
  assign imm16  = cur_instr[15:0];

  // Same-cycle writeback is forwarded so ID never reads a stale value.
  assign rs_data = (rs == 5'd0) ? '0 :
                   (bus.wb_we && bus.wb_addr == rs) ? bus.wb_data : regs_q[rs];
  assign rt_data = (rt == 5'd0) ? '0 :
                   (bus.wb_we && bus.wb_addr == rt) ? bus.wb_data : regs_q[rt];

  always_comb begin
    legal       = 1'b0;
    uses_rs     = 1'b0;
    uses_rt     = 1'b0;
    dest        = 5'd0;
    alu_src_imm = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    link        = 1'b0;
    is_beq      = 1'b0;
    is_bne      = 1'b0;
    is_jump     = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          F_SLL, F_SRL, F_SRA: begin
            legal   = 1'b1;
            uses_rt = 1'b1;
            dest    = rd;
          end
          F_ADD, F_ADDU, F_SUB, F_SUBU, F_AND, F_OR, F_XOR, F_NOR, F_SLT, F_SLTU: begin
            legal   = 1'b1;
            uses_rs = 1'b1;
            uses_rt = 1'b1;
            dest    = rd;
          end
          default: ;
        endcase
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI: begin
        legal       = 1'b1;
        uses_rs     = 1'b1;
        dest        = rt;
        alu_src_imm = 1'b1;
      end
      OP_LUI: begin
        legal       = 1'b1;
        dest        = rt;
        alu_src_imm = 1'b1;
      end
      OP_LW: begin
        legal       = 1'b1;
        uses_rs     = 1'b1;
        dest        = rt;
        alu_src_imm = 1'b1;
        mem_read    = 1'b1;
      end
      OP_SW: begin
        legal       = 1'b1;
        uses_rs     = 1'b1;
        uses_rt     = 1'b1;
        alu_src_imm = 1'b1;
        mem_write   = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        legal   = 1'b1;
        uses_rs = 1'b1;
        uses_rt = 1'b1;
        is_beq  = (opcode == OP_BEQ);
        is_bne  = (opcode == OP_BNE);
      end
      OP_J: begin
        legal   = 1'b1;
        is_jump = 1'b1;
      end
      OP_JAL: begin
        legal   = 1'b1;
        is_jump = 1'b1;
        link    = 1'b1;
        dest    = 5'd31;
      end
      default: ;
    endcase
  end

  always_comb begin
    imm_ext = {{(WIDTH-16){imm16[15]}}, imm16};
    case (opcode)
      OP_ANDI, OP_ORI, OP_XORI: imm_ext = {{(WIDTH-16){1'b0}}, imm16};
      OP_LUI:                   imm_ext = {imm16, {(WIDTH-16){1'b0}}};
      default: ;
    endcase
  end

  assign ex_hit_rs  = (bus.ex_dest != 5'd0)  && (bus.ex_dest == rs);
  assign ex_hit_rt  = (bus.ex_dest != 5'd0)  && (bus.ex_dest == rt);
  assign mem_hit_rs = (bus.mem_dest != 5'd0) && (bus.mem_dest == rs);
  assign mem_hit_rt = (bus.mem_dest != 5'd0) && (bus.mem_dest == rt);

  assign load_use = bus.ex_mem_read && ((uses_rs && ex_hit_rs) || (uses_rt && ex_hit_rt));
  // Branches compare in ID, so any in-flight producer of an operand (ALU in EX, load in MEM) must drain first.
  assign branch_hazard = (is_beq || is_bne) &&
                         ((bus.ex_reg_write && (ex_hit_rs || ex_hit_rt)) ||
                          (bus.mem_mem_read && (mem_hit_rs || mem_hit_rt)));
  assign stall = load_use || branch_hazard;

  assign pc_plus4  = cur_pc + WIDTH'(4);
  assign br_offset = {{(WIDTH-18){imm16[15]}}, imm16, 2'b00};
  assign taken_raw = (is_beq && (rs_data == rt_data)) ||
                     (is_bne && (rs_data != rt_data)) ||
                     is_jump;
  assign taken     = taken_raw && !stall;

  always_comb begin
    target = '0;
    if (taken) begin
      if (is_jump) target = {pc_plus4[WIDTH-1:WIDTH-4], cur_instr[25:0], 2'b00};
      else         target = pc_plus4 + br_offset;
    end
  end

  always_comb begin
    hold_valid_d = stall;
    hold_instr_d = hold_instr_q;
    hold_pc_d    = hold_pc_q;
    if (stall) begin
      hold_instr_d = cur_instr;
      hold_pc_d    = cur_pc;
    end
  end

  always_comb begin
    idex_d    = '0;
    idex_d.pc = cur_pc;
    if (!stall) begin
      idex_d.rs_data     = rs_data;
      idex_d.rt_data     = rt_data;
      idex_d.imm         = imm_ext;
      idex_d.dest        = dest;
      idex_d.opcode      = opcode;
      idex_d.funct       = funct;
      idex_d.shamt       = shamt;
      idex_d.alu_src_imm = alu_src_imm;
      idex_d.reg_write   = (dest != 5'd0);
      idex_d.mem_read    = mem_read;
      idex_d.mem_write   = mem_write;
      idex_d.link        = link;
      idex_d.illegal     = !legal;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < REG_COUNT; i++) regs_q[i] <= '0;
    end else if (bus.wb_we && bus.wb_addr != 5'd0) begin
      regs_q[bus.wb_addr] <= bus.wb_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_valid_q <= 1'b0;
      hold_instr_q <= '0;
      hold_pc_q    <= '0;
      idex_q       <= '0;
    end else begin
      hold_valid_q <= hold_valid_d;
      hold_instr_q <= hold_instr_d;
      hold_pc_q    <= hold_pc_d;
      idex_q       <= idex_d;
    end
  end

  assign bus.stall          = stall;
  assign bus.branch_taken   = taken;
  assign bus.branch_target  = target;
  assign bus.id_pc          = idex_q.pc;
  assign bus.id_rs_data     = idex_q.rs_data;
  assign bus.id_rt_data     = idex_q.rt_data;
  assign bus.id_imm         = idex_q.imm;
  assign bus.id_dest        = idex_q.dest;
  assign bus.id_opcode      = idex_q.opcode;
  assign bus.id_funct       = idex_q.funct;
  assign bus.id_shamt       = idex_q.shamt;
  assign bus.id_alu_src_imm = idex_q.alu_src_imm;
  assign bus.id_reg_write   = idex_q.reg_write;
  assign bus.id_mem_read    = idex_q.mem_read;
  assign bus.id_mem_write   = idex_q.mem_write;
  assign bus.id_link        = idex_q.link;
  assign bus.id_illegal     = idex_q.illegal;

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- ID stage of the MIPS R2000 pipeline, directly downstream of fetch.
- Consumes the fetch stage's registered pc/instruction pair and reads the 32x32 register file.
- Resolves beq/bne/j/jal in ID, driving branch_taken/branch_target back to fetch.
- Detects data hazards, drives stall to fetch, and registers decoded fields into the ID/EX buffer.

Parameters:
WIDTH, 32, datapath/address width (Constants::WIDTH)
REG_COUNT, 32, architectural registers; index width = 5

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
pc_fetched  input  WIDTH  pc of instruction from fetch buffer
instruction_fetched  input  WIDTH  instruction from fetch buffer (0 = nop/bubble)
wb_we  input  1  register file write enable
wb_addr  input  5  register file write index
wb_data  input  WIDTH  register file write data
ex_reg_write  input  1  instruction in EX writes a register
ex_mem_read  input  1  instruction in EX is lw
ex_dest  input  5  EX destination register
mem_mem_read  input  1  instruction in MEM is lw
mem_dest  input  5  MEM destination register
stall  output  1  combinational; hold fetch pc, bubble fetch buffer
branch_taken  output  1  combinational; redirect fetch
branch_target  output  WIDTH  combinational redirect address
id_pc, id_rs_data, id_rt_data, id_imm  output  WIDTH each  registered
id_dest  output  5  registered destination (0 = none)
id_opcode, id_funct  output  6 each  registered
id_shamt  output  5  registered
id_alu_src_imm, id_reg_write, id_mem_read, id_mem_write, id_link, id_illegal  output  1 each  registered

Behaviour:
- Register file: r0 reads 0 and ignores writes. Write on posedge when wb_we. Read bypass: if wb_we && wb_addr==index && index!=0, read returns wb_data in the same cycle. rst clears all registers to 0.
- Replay holder: fetch zeroes the instruction on stall, so ID keeps its own copy.
  - On any posedge with stall=1: hold_valid<=1, hold_instr<=cur_instr, hold_pc<=cur_pc.
  - On a posedge with stall=0: hold_valid<=0.
  - cur_* = hold_valid ? hold_* : *_fetched.
- Field decode from cur_instr: rs[25:21], rt[20:16], rd[15:11], shamt[10:6], funct[5:0], imm16. Immediate extension:
  - andi/ori/xori: zero-extend.
  - lui: {imm16,16'b0}.
  - Others: sign-extend.
- Supported instructions:
  - R-type: add addu sub subu and or xor nor slt sltu sll srl sra.
  - I-type: addi addiu andi ori xori slti sltiu lui lw sw beq bne.
  - J-type: j jal.
  - Anything else: id_illegal=1 with all control bits 0 (acts as nop).
- Destination register: R-type -> rd; I-type ALU/lw -> rt; jal -> 31; sw/beq/bne/j -> 0. id_reg_write = (dest!=0).
- Hazard/stall (combinational):
  - Load-use: ex_mem_read && ex_dest!=0 && ex_dest matches a source actually read by cur_instr.
  - Branch operand: cur_instr is beq/bne && (ex_reg_write && ex_dest!=0 && ex_dest in {rs,rt}), or (mem_mem_read && mem_dest!=0 && mem_dest in {rs,rt}).
- Branch resolution, gated by !stall:
  - beq taken if rs==rt; bne taken if rs!=rt. Target = cur_pc+4+(sext(imm16)<<2), mod 2^32.
  - j/jal always taken. Target = {(cur_pc+4)[31:28], instr[25:0], 2'b00}.
  - No architectural delay slot; fetch substitutes the target instruction.
  - branch_target = 0 when not taken.
- ID/EX buffer (posedge):
  - stall=1: insert bubble (all id_* 0 except id_pc=cur_pc).
  - Otherwise: latch the decoded fields.
  - jal: id_link=1, id_dest=31; EX writes id_pc+4.
- Reset (async, rst=1): all id_* outputs 0, hold_valid=0, register file 0. stall and branch_taken evaluate to 0 since instruction 0 is sll $0 (nop).
- Reset mid-stall discards the held instruction. Reset deassertion takes effect at the next posedge.
- Latency: 1 cycle from fetch buffer to id_* outputs. Stall and branch outputs are same-cycle combinational.

Test Plan:
1. Reset: rst=1 mid-run with hold_valid=1 -> all id_* 0, stall=0, branch_taken=0; next instr decodes from instruction_fetched.
2. Bypass: wb_we=1, wb_addr=5, wb_data=32'h1234_5678 while decoding addu $3,$5,$0 -> id_rs_data=32'h1234_5678 next cycle; write to r0 -> reads 0.
3. Load-use: ex_mem_read=1, ex_dest=8, ID holds add $9,$8,$8 -> stall=1 for one cycle, bubble in ID/EX. Next cycle with instruction_fetched=0, replayed add is latched with id_dest=9.
4. beq taken: pc=32'h0000_0010, beq $1,$2,+3 with r1=r2=7 -> branch_taken=1, branch_target=32'h0000_0020. With r2=8 -> branch_taken=0.
5. jal at pc=32'h0040_0000, index 26'h000_0040 -> branch_target=32'h0000_0100, id_link=1, id_dest=31, id_reg_write=1.
6. Branch hazard: ex_reg_write=1, ex_dest=1, bne $1,$0 -> stall=1, branch_taken=0. Next cycle ex_reg_write=0 -> branch resolves with r1 value.
